// File: rtl/axi_burst_splitter_if.sv
// axi_burst_splitter_if: AXI4 port bundle (aw/w/b/ar/r channels) with master and slave views
interface axi_burst_splitter_if #(
  parameter int AddressWidth = 32,
  parameter int DataWidth = 32,
  parameter int TransactionIdWidth = 8
);
  logic awvalid, awready;
  logic [TransactionIdWidth-1:0] awid;
  logic [AddressWidth-1:0] awaddr;
  logic [7:0] awlen;
  logic [2:0] awsize;
  logic [1:0] awburst;
  logic wvalid, wready, wlast;
  logic [DataWidth-1:0] wdata;
  logic [DataWidth/8-1:0] wstrb;
  logic bvalid, bready;
  logic [TransactionIdWidth-1:0] bid;
  logic [1:0] bresp;
  logic arvalid, arready;
  logic [TransactionIdWidth-1:0] arid;
  logic [AddressWidth-1:0] araddr;
  logic [7:0] arlen;
  logic [2:0] arsize;
  logic [1:0] arburst;
  logic rvalid, rready, rlast;
  logic [TransactionIdWidth-1:0] rid;
  logic [DataWidth-1:0] rdata;
  logic [1:0] rresp;
  modport master (
    output awvalid, awid, awaddr, awlen, awsize, awburst, wvalid, wdata, wstrb, wlast, bready,
           arvalid, arid, araddr, arlen, arsize, arburst, rready,
    input  awready, wready, bvalid, bid, bresp, arready, rvalid, rid, rdata, rresp, rlast
  );
  modport slave (
    input  awvalid, awid, awaddr, awlen, awsize, awburst, wvalid, wdata, wstrb, wlast, bready,
           arvalid, arid, araddr, arlen, arsize, arburst, rready,
    output awready, wready, bvalid, bid, bresp, arready, rvalid, rid, rdata, rresp, rlast
  );
endinterface

// File: rtl/axi_burst_splitter.sv
// axi_burst_splitter: splits INCR bursts into sub-bursts of at most MaxBeats beats
// AXI_BURST_SPLITTER_4K_EN additionally keeps each sub-burst inside one 4 KB page
module axi_burst_splitter #(
  parameter int AddressWidth = 32,
  parameter int DataWidth = 32,
  parameter int TransactionIdWidth = 8,
  parameter int MaxBeats = 4
) (
  input logic clk,
  input logic rst,
  axi_burst_splitter_if.slave s,
  axi_burst_splitter_if.master m
);
  typedef enum logic [2:0] {W_IDLE, W_ADDR, W_DATA, W_RESP, W_DONE} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;
  localparam logic [8:0] MB = 9'(MaxBeats);
  w_state_t w_state, w_next;
  r_state_t r_state, r_next;
  logic [TransactionIdWidth-1:0] w_id, r_id;
  logic [AddressWidth-1:0] w_addr, r_addr;
  logic [2:0] w_size, r_size;
  logic [1:0] w_burst, r_burst, w_resp, b_merged;
  logic [8:0] w_rem, w_beats, w_cnt, w_nb, w_lim, r_rem, r_beats, r_nb, r_lim;
  logic w_hs, r_hs, unused_ok;
  function automatic logic [8:0] cap(input logic [8:0] rem, input logic [8:0] lim);
    return rem > lim ? lim : rem;
  endfunction
`ifdef AXI_BURST_SPLITTER_4K_EN
  // beats left before the next 4 KB page; never below one so a misaligned tail still progresses
  function automatic logic [8:0] lim_4k(input logic [11:0] a);
    logic [12:0] l;
    l = (13'h1000 - {1'b0, a}) >> 2;
    return l == 13'd0 ? 9'd1 : (l > 13'(MB) ? MB : l[8:0]);
  endfunction
  assign w_lim = lim_4k(w_addr[11:0]);
  assign r_lim = lim_4k(r_addr[11:0]);
`else
  assign w_lim = MB;
  assign r_lim = MB;
`endif
  assign w_nb = (w_burst == 2'b01 && w_size == 3'd2) ? cap(w_rem, w_lim) : w_rem;
  assign r_nb = (r_burst == 2'b01 && r_size == 3'd2) ? cap(r_rem, r_lim) : r_rem;
  assign b_merged = m.bresp == 2'b01 ? 2'b00 : m.bresp;
  assign unused_ok = ^{s.wlast, m.bid};
  assign s.awready = w_state == W_IDLE && !rst;
  assign m.awvalid = w_state == W_ADDR;
  assign m.awid = w_id;
  assign m.awaddr = w_addr;
  assign m.awlen = w_state == W_ADDR ? 8'(w_nb - 9'd1) : 8'd0;
  assign m.awsize = w_size;
  assign m.awburst = w_burst;
  assign m.wvalid = w_state == W_DATA && s.wvalid;
  assign s.wready = w_state == W_DATA && m.wready;
  assign m.wdata = w_state == W_DATA ? s.wdata : '0;
  assign m.wstrb = w_state == W_DATA ? s.wstrb : {DataWidth/8{1'b0}};
  assign m.wlast = w_state == W_DATA && w_cnt == w_beats - 9'd1;
  assign m.bready = w_state == W_RESP;
  assign s.bvalid = w_state == W_DONE;
  assign s.bid = w_id;
  assign s.bresp = w_resp;
  assign w_hs = m.wvalid && m.wready;
  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE: w_next = s.awvalid ? W_ADDR : W_IDLE;
      W_ADDR: w_next = m.awready ? W_DATA : W_ADDR;
      W_DATA: w_next = w_hs && m.wlast ? W_RESP : W_DATA;
      W_RESP: w_next = !m.bvalid ? W_RESP : (w_rem == w_beats ? W_DONE : W_ADDR);
      W_DONE: w_next = s.bready ? W_IDLE : W_DONE;
      default: w_next = W_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      w_state <= W_IDLE;
      w_id <= '0;
      w_addr <= '0;
      w_size <= '0;
      w_burst <= '0;
      w_rem <= '0;
      w_beats <= '0;
      w_cnt <= '0;
      w_resp <= '0;
    end else begin
      w_state <= w_next;
      if (s.awvalid && s.awready) begin
        w_id <= s.awid;
        w_addr <= s.awaddr;
        w_size <= s.awsize;
        w_burst <= s.awburst;
        w_rem <= 9'(s.awlen) + 9'd1;
        w_resp <= 2'b00;
      end
      if (m.awvalid && m.awready) begin
        w_beats <= w_nb;
        w_cnt <= '0;
      end
      if (w_hs) w_cnt <= w_cnt + 9'd1;
      if (m.bvalid && m.bready) begin
        w_addr <= w_addr + AddressWidth'({w_beats, 2'b00});
        w_rem <= w_rem - w_beats;
        w_resp <= b_merged > w_resp ? b_merged : w_resp;
      end
    end
  assign s.arready = r_state == R_IDLE && !rst;
  assign m.arvalid = r_state == R_ADDR;
  assign m.arid = r_id;
  assign m.araddr = r_addr;
  assign m.arlen = r_state == R_ADDR ? 8'(r_nb - 9'd1) : 8'd0;
  assign m.arsize = r_size;
  assign m.arburst = r_burst;
  assign s.rvalid = r_state == R_DATA && m.rvalid;
  assign m.rready = r_state == R_DATA && s.rready;
  assign s.rid = r_state == R_DATA ? m.rid : '0;
  assign s.rdata = r_state == R_DATA ? m.rdata : '0;
  assign s.rresp = r_state == R_DATA ? m.rresp : 2'b00;
  // only the closing beat of the final sub-burst ends the upstream burst
  assign s.rlast = r_state == R_DATA && m.rlast && r_rem == r_beats;
  assign r_hs = m.rvalid && m.rready && m.rlast;
  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE: r_next = s.arvalid ? R_ADDR : R_IDLE;
      R_ADDR: r_next = m.arready ? R_DATA : R_ADDR;
      R_DATA: r_next = !r_hs ? R_DATA : (r_rem == r_beats ? R_IDLE : R_ADDR);
      default: r_next = R_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= R_IDLE;
      r_id <= '0;
      r_addr <= '0;
      r_size <= '0;
      r_burst <= '0;
      r_rem <= '0;
      r_beats <= '0;
    end else begin
      r_state <= r_next;
      if (s.arvalid && s.arready) begin
        r_id <= s.arid;
        r_addr <= s.araddr;
        r_size <= s.arsize;
        r_burst <= s.arburst;
        r_rem <= 9'(s.arlen) + 9'd1;
      end
      if (m.arvalid && m.arready) r_beats <= r_nb;
      if (r_state == R_DATA && r_hs) begin
        r_addr <= r_addr + AddressWidth'({r_beats, 2'b00});
        r_rem <= r_rem - r_beats;
      end
    end
endmodule
